stack_unit: RTL and testbench
=============================

// Module: stack_unit
// PURPOSE
//   Parametrised LIFO operand stack for the multicycle stack CPU; replaces the fixed 8-bit stack.
//   Single-cycle push/pop/replace/swap with live TOS and NOS (next-on-stack) outputs.
//   Exposes occupancy, full/empty and overflow/underflow error flags.
//   Control FSM drives push/pop/swap; datapath consumes tos/nos for A/B loads and jz tests.
// PARAMETERS
//   WIDTH   8   data word width in bits (>=1)
//   DEPTH   16  number of entries (>=2; need not be a power of two)
//   CW      $clog2(DEPTH+1)  count width (localparam, derived)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-low reset
//   push       in   1      push din (or replace TOS when pop also high)
//   pop        in   1      discard TOS
//   swap       in   1      exchange TOS and NOS; honoured only when push=pop=0
//   din        in   WIDTH  data to push
//   err_clr    in   1      clear sticky error flags (used only with STACK_ERR_STICKY_EN)
//   tos        out  WIDTH  top of stack; 0 when count==0
//   nos        out  WIDTH  entry below TOS; 0 when count<2
//   count      out  CW     number of valid entries, 0..DEPTH
//   empty      out  1      count==0
//   full       out  1      count==DEPTH
//   overflow   out  1      push refused (stack full)
//   underflow  out  1      pop/swap refused (too few entries)
// BEHAVIOUR
//   - Storage: DEPTH x WIDTH register array, mem[0]=bottom; count is the write index.
//   - Reset (rst=0, async): count=0, overflow=underflow=0 -> tos=0, nos=0, empty=1, full=0.
//     Array contents are not reset; tos/nos are masked to 0 so no X reaches outputs.
//   - Every operation takes effect at the rising edge; tos/nos/count/flags reflect it the same
//     cycle after the edge (tos/nos are combinational reads of array at count-1/count-2).
//   - Operation decode per edge (priority top to bottom):
//     push&pop, count>=1 : mem[count-1]<=din, count unchanged (replace TOS)
//     push&pop, count==0 : acts as push: mem[0]<=din, count=1; no error
//     push only, !full   : mem[count]<=din, count+1
//     push only, full    : no state change; overflow event
//     pop only, !empty   : count-1 (data left in array, not cleared)
//     pop only, empty    : no state change; underflow event
//     swap, count>=2     : mem[count-1]<=mem[count-2], mem[count-2]<=mem[count-1]
//     swap, count<2      : no state change; underflow event
//     none               : hold
//   - swap asserted with push or pop is ignored without error.
//   - Error flags (default build): overflow/underflow are single-cycle pulses, high for exactly
//     the cycle following the refused operation's edge; err_clr has no effect.
//   - count never wraps: saturates at 0 and DEPTH by refusal, not arithmetic.
//   - Reset asserted mid-sequence discards all pending state immediately (no edge needed).
// CONFIGURATION
//   STACK_ERR_STICKY_EN defined: overflow/underflow become sticky; set by a refused op, held
//     until err_clr=1 at an edge (clear wins over a same-edge set). Reset still clears them.
//   STACK_ERR_STICKY_EN undefined: pulse behaviour above; err_clr ignored.
// TESTING
//   T1 reset: rst=0 -> count=0, empty=1, full=0, tos=0, nos=0, flags 0, even with push=1 held.
//   T2 fill: push 0x01..0x10 (DEPTH=16) -> count=16, full=1, tos=0x10, nos=0x0F;
//      17th push 0xAA -> count=16, tos=0x10, overflow=1 one cycle (sticky build: stays 1).
//   T3 drain: 16 pops -> tos steps 0x0F..0x01 then 0, empty=1; extra pop -> underflow=1, count=0.
//   T4 replace: push 0x05, push 0x07, push&pop din=0x09 -> count=2, tos=0x09, nos=0x05;
//      push&pop on empty stack din=0x33 -> count=1, tos=0x33, no error.
//   T5 swap: stack [0x05,0x09] swap -> tos=0x05, nos=0x09; swap with count=1 -> underflow,
//      tos unchanged; swap+pop together -> pop only, no error.
//   T6 sticky (STACK_ERR_STICKY_EN): underflow, wait 5 cycles -> still 1; err_clr with
//      simultaneous refused pop -> 0 next cycle; async rst mid-fill -> count=0 immediately.

Source files
------------

// File: rtl/stack_unit.sv
// stack_unit: parametrised LIFO operand stack with live TOS/NOS outputs and error flags.
// Define STACK_ERR_STICKY_EN to make overflow/underflow sticky until err_clr.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             swap,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] top, below;
  logic do_rep, do_push, do_pop, do_swap, ovf_ev, unf_ev, swap_only;
  always_comb begin
    top       = AW'(count - CW'(1));
    below     = AW'(count - CW'(2));
    empty     = count == '0;
    full      = count == CW'(DEPTH);
    tos       = empty ? '0 : mem[top];
    nos       = count < CW'(2) ? '0 : mem[below];
    swap_only = swap & ~push & ~pop;
    do_rep    = push & pop & ~empty;
    do_push   = push & ~do_rep & ~full;
    do_pop    = pop & ~push & ~empty;
    do_swap   = swap_only & (count >= CW'(2));
    ovf_ev    = push & ~pop & full;
    unf_ev    = (pop & ~push & empty) | (swap_only & (count < CW'(2)));
  end
  // Array is deliberately left unreset; outputs are masked by count instead.
  always_ff @(posedge clk) begin
    if (do_rep) mem[top] <= din;
    else if (do_push) mem[AW'(count)] <= din;
    else if (do_swap) begin
      mem[top]   <= mem[below];
      mem[below] <= mem[top];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) count <= count + CW'(1);
      else if (do_pop) count <= count - CW'(1);
`ifdef STACK_ERR_STICKY_EN
      overflow  <= err_clr ? 1'b0 : (overflow | ovf_ev);
      underflow <= err_clr ? 1'b0 : (underflow | unf_ev);
`else
      overflow  <= ovf_ev;
      underflow <= unf_ev;
`endif
    end
  end
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: scoreboard bench for stack_unit (DEPTH=16, WIDTH=8); sticky tests under STACK_ERR_STICKY_EN.
module tb_stack_unit;
  typedef logic [24:0] obs_t;
  logic clk = 1'b0, rst = 1'b0, push = 1'b0, pop = 1'b0, swap = 1'b0, err_clr = 1'b0;
  logic [7:0] din = '0, tos, nos;
  logic [4:0] count;
  logic empty, full, overflow, underflow;
  int vectors = 0, miscompares = 0;
  obs_t q[$];
  obs_t e;
  logic [7:0] mm [16];
  int mc = 0;
  logic mov = 1'b0, mun = 1'b0;

  stack_unit #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .swap(swap), .din(din), .err_clr(err_clr),
    .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic obs_t observed();
    return {count, tos, nos, overflow, underflow, empty, full};
  endfunction

  function automatic obs_t expv();
    logic [7:0] t, n;
    t = mc > 0 ? mm[mc-1] : 8'h00;
    n = mc > 1 ? mm[mc-2] : 8'h00;
    return {5'(mc), t, n, mov, mun, mc == 0, mc == 16};
  endfunction

  task automatic model_reset();
    mc = 0; mov = 1'b0; mun = 1'b0;
    q.push_back(expv());
  endtask

  task automatic step(input logic p, input logic po, input logic s, input logic [7:0] d, input logic ec);
    logic ov_ev, un_ev;
    logic [7:0] t;
    push = p; pop = po; swap = s; din = d; err_clr = ec;
    ov_ev = p && !po && mc == 16;
    un_ev = (po && !p && mc == 0) || (s && !p && !po && mc < 2);
    if (p && po && mc > 0) mm[mc-1] = d;
    else if (p && mc < 16) begin mm[mc] = d; mc++; end
    else if (po && !p && mc > 0) mc--;
    else if (s && !p && !po && mc >= 2) begin
      t = mm[mc-1]; mm[mc-1] = mm[mc-2]; mm[mc-2] = t;
    end
`ifdef STACK_ERR_STICKY_EN
    mov = ec ? 1'b0 : (mov | ov_ev);
    mun = ec ? 1'b0 : (mun | un_ev);
`else
    mov = ov_ev;
    mun = un_ev;
`endif
    q.push_back(expv());
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; swap = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    e = q.pop_front();
    vectors++;
    if (observed() !== e) begin
      miscompares++;
      $display("FAIL reset_async got=%h want=%h", observed(), e);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    push = 1'b1; din = 8'h5A;
    rst = 1'b0;
    model_reset();
    #1;
    e = q.pop_front();
    vectors++;
    if (observed() !== e) begin
      miscompares++;
      $display("FAIL reset_immediate got=%h want=%h", observed(), e);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (observed() !== e) begin
      miscompares++;
      $display("FAIL reset_push_held got=%h want=%h", observed(), e);
    end
    push = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(i), 1'b0);
      e = q.pop_front();
      vectors++;
      if (observed() !== e) begin
        miscompares++;
        $display("FAIL fill_%0d got=%h want=%h", i, observed(), e);
      end
    end
    step(1'b1, 1'b0, 1'b0, 8'hAA, 1'b0);
    e = q.pop_front();
    vectors++;
    if (observed() !== e || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow got=%h want=%h", observed(), e);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    e = q.pop_front();
    vectors++;
    if (observed() !== e) begin
      miscompares++;
      $display("FAIL overflow_after got=%h want=%h", observed(), e);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      e = q.pop_front();
      vectors++;
      if (observed() !== e) begin
        miscompares++;
        $display("FAIL drain_%0d got=%h want=%h", i, observed(), e);
      end
    end
    vectors++;
    if (underflow !== 1'b1 || count !== 5'd0) begin
      miscompares++;
      $display("FAIL underflow_empty got=%b/%0d want=1/0", underflow, count);
    end
  endtask

  task automatic test_replace();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h05, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h07, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h09, 1'b0);
    repeat (2) void'(q.pop_front());
    e = q.pop_front();
    vectors++;
    if (observed() !== e || tos !== 8'h09 || nos !== 8'h05) begin
      miscompares++;
      $display("FAIL replace got=%h want=%h", observed(), e);
    end
  endtask

  task automatic test_swap();
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    e = q.pop_front();
    vectors++;
    if (observed() !== e || tos !== 8'h05 || nos !== 8'h09) begin
      miscompares++;
      $display("FAIL swap got=%h want=%h", observed(), e);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    void'(q.pop_front());
    e = q.pop_front();
    vectors++;
    if (observed() !== e || underflow !== 1'b1) begin
      miscompares++;
      $display("FAIL swap_underflow got=%h want=%h", observed(), e);
    end
    step(1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    void'(q.pop_front());
    e = q.pop_front();
    vectors++;
    if (observed() !== e) begin
      miscompares++;
      $display("FAIL swap_with_pop got=%h want=%h", observed(), e);
    end
  endtask

  task automatic test_replace_empty();
    while (mc > 0) begin
      step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      void'(q.pop_front());
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    void'(q.pop_front());
    step(1'b1, 1'b1, 1'b0, 8'h33, 1'b0);
    e = q.pop_front();
    vectors++;
    if (observed() !== e || tos !== 8'h33 || count !== 5'd1) begin
      miscompares++;
      $display("FAIL replace_empty got=%h want=%h", observed(), e);
    end
  endtask

  task automatic test_err_clr();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      void'(q.pop_front());
    end
    e = q.pop_front();
    e = q.size() == 0 ? expv() : e;
    vectors++;
    if (observed() !== e) begin
      miscompares++;
      $display("FAIL err_hold got=%h want=%h", observed(), e);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    e = q.pop_front();
    vectors++;
    if (observed() !== e) begin
      miscompares++;
      $display("FAIL err_clr_vs_set got=%h want=%h", observed(), e);
    end
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i), 1'b0);
      void'(q.pop_front());
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    e = q.pop_front();
    vectors++;
    if (observed() !== e) begin
      miscompares++;
      $display("FAIL reset_mid_fill got=%h want=%h", observed(), e);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    int r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 15);
      step(r < 7, r >= 5 && r < 12, r >= 11, 8'($urandom), $urandom_range(0, 3) == 0);
      e = q.pop_front();
      vectors++;
      if (observed() !== e) begin
        miscompares++;
        $display("FAIL b2b_%0d got=%h want=%h", i, observed(), e);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_fill();
    test_drain();
    test_replace();
    test_swap();
    test_replace_empty();
    test_err_clr();
    test_reset_mid_fill();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
